// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN input packer: legal matrix sizes, SRAM word
// constants, default widths and the packer FSM state encoding.
package bnn_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    localparam logic [4:0]  SIZE_10   = 5'd10;
    localparam logic [4:0]  SIZE_12   = 5'd12;
    localparam logic [4:0]  SIZE_16   = 5'd16;
    localparam logic [15:0] TERM_WORD = 16'h0000;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_HDR,
        HDR,
        ROW,
        WRROW,
        TERM,
        RUN,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_e;

    function automatic logic size_legal(input logic [4:0] n);
        return (n == SIZE_10) || (n == SIZE_12) || (n == SIZE_16);
    endfunction

endpackage

// File: rtl/bnn_row_shifter.sv
// Row assembly register: drops each accepted pixel at bit position col, and
// flags the pixel that completes a row of len_i columns.
module bnn_row_shifter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              clear_i,
    input  logic              shift_en_i,
    input  logic              bit_i,
    input  logic [4:0]        len_i,
    output logic [DATA_W-1:0] row_d_o,
    output logic              row_full_o
);
    localparam int CIDX_W = $clog2(DATA_W);

    logic [DATA_W-1:0] row_q, row_d;
    logic [4:0]        col_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        row_d = row_q;
        if (shift_en_i) row_d[col_q[CIDX_W-1:0]] = bit_i;
    end

    assign row_d_o    = row_d;
    assign row_full_o = shift_en_i && (col_q == len_i - 5'd1);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (shift_en_i) begin
            row_q <= row_d;
            col_q <= col_q + 5'd1;
        end
    end

endmodule

// File: rtl/bnn_input_packer.sv
// Packs a bit-serial feature-map stream into the BNN engine's input-SRAM image
// and runs the engine. Define BNN_PACKER_AUTORUN_EN to launch without go.
module bnn_input_packer
    import bnn_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              load_start,
    input  logic [4:0]        cfg_size,
    input  logic              go,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_data,
    input  logic              s_last,
    output logic [ADDR_W-1:0] sram_write_address,
    output logic [DATA_W-1:0] sram_write_data,
    output logic              sram_write_enable,
    output logic              dut_run,
    input  logic              dut_busy,
    output logic              packer_busy,
    output logic              done,
    output logic              err
);
    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        size_q;
    logic [4:0]        row_idx_q;
    logic              last_q;
    logic              s_ready_q, we_q, run_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept, row_full;
    logic [DATA_W-1:0] row_word;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   need;
    logic              fits;

    assign accept = s_valid && s_ready_q;

    bnn_row_shifter #(.DATA_W(DATA_W)) u_row (
        .clk        (clk),
        .reset_b    (reset_b),
        .clear_i    (state_q == WRROW),
        .shift_en_i (accept),
        .bit_i      (s_data),
        .len_i      (size_q),
        .row_d_o    (row_word),
        .row_full_o (row_full)
    );

    // A fresh run always builds its image from word 0.
    assign base_addr = (state_q == IDLE) ? '0 : addr_q;
    assign need      = {1'b0, base_addr} + (ADDR_W+1)'(cfg_size) + (ADDR_W+1)'(2);
    assign fits      = need <= ((ADDR_W+1)'(1) << ADDR_W);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            row_idx_q <= '0;
            last_q    <= 1'b0;
            s_ready_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE, WAIT_HDR: begin
                    if (load_start) begin
                        if (size_legal(cfg_size) && fits) begin
                            size_q    <= cfg_size;
                            row_idx_q <= '0;
                            busy_q    <= 1'b1;
                            we_q      <= 1'b1;
                            waddr_q   <= base_addr;
                            wdata_q   <= DATA_W'(cfg_size);
                            addr_q    <= base_addr + ADDR_W'(1);
                            state_q   <= HDR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    s_ready_q <= 1'b1;
                    state_q   <= ROW;
                end
                ROW: begin
                    if (row_full) begin
                        s_ready_q <= 1'b0;
                        last_q    <= s_last;
                        we_q      <= 1'b1;
                        waddr_q   <= addr_q;
                        wdata_q   <= row_word;
                        addr_q    <= addr_q + ADDR_W'(1);
                        state_q   <= WRROW;
                    end
                end
                WRROW: begin
                    if (row_idx_q != size_q - 5'd1) begin
                        row_idx_q <= row_idx_q + 5'd1;
                        s_ready_q <= 1'b1;
                        state_q   <= ROW;
                    end else if (last_q) begin
                        we_q    <= 1'b1;
                        waddr_q <= addr_q;
                        wdata_q <= DATA_W'(TERM_WORD);
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= TERM;
                    end else begin
                        state_q <= WAIT_HDR;
                    end
                end
                TERM: begin
`ifdef BNN_PACKER_AUTORUN_EN
                    run_q <= 1'b1;
`endif
                    state_q <= RUN;
                end
                RUN: begin
`ifdef BNN_PACKER_AUTORUN_EN
                    state_q <= WAIT_HI;
`else
                    if (go) begin
                        run_q   <= 1'b1;
                        state_q <= WAIT_HI;
                    end
`endif
                end
                WAIT_HI: if (dut_busy) state_q <= WAIT_LO;
                WAIT_LO: begin
                    if (!dut_busy) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready            = s_ready_q;
    assign sram_write_enable  = we_q;
    assign sram_write_address = waddr_q;
    assign sram_write_data    = wdata_q;
    assign dut_run            = run_q;
    assign packer_busy        = busy_q;
    assign done               = done_q;
    assign err                = err_q;

endmodule
